// File: rtl/pipeline_ctrl_pkg.sv
// Shared types and widths for the pipeline hazard/stall controller.
// Holds the FSM state enum, the control-word struct and the load-use hazard helper.
package pipeline_ctrl_pkg;

  localparam int MUL_CNT_W   = 4;
  localparam int STALL_CNT_W = 16;
  localparam int REG_W       = 5;

  typedef enum logic [0:0] {
    RUN      = 1'b0,
    MUL_WAIT = 1'b1
  } state_e;

  typedef struct packed {
    logic pc_write;
    logic ifid_write;
    logic if_flush;
    logic idex_write;
    logic idex_bubble;
    logic exmem_bubble;
    logic busy;
  } ctrl_t;

  localparam ctrl_t CTRL_RUN   = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
  localparam ctrl_t CTRL_STALL = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
  localparam ctrl_t CTRL_FLUSH = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
  localparam ctrl_t CTRL_MULW  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
  localparam ctrl_t CTRL_RESET = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};

  // A load into $zero never creates a real dependency, so it cannot stall.
  function automatic logic load_use_hazard(
    input logic             mem_read,
    input logic [REG_W-1:0] ex_rt,
    input logic [REG_W-1:0] id_rs,
    input logic [REG_W-1:0] id_rt
  );
    return mem_read & (ex_rt != {REG_W{1'b0}}) & ((ex_rt == id_rs) | (ex_rt == id_rt));
  endfunction

endpackage

// File: rtl/pipeline_ctrl_sat_counter.sv
// Saturating up-counter with enable and asynchronous active-low clear.
// Once the count reaches all-ones it holds there until cleared.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         clr_n,
  input  logic         en_i,
  output logic [W-1:0] count_o
);

  logic [W-1:0] count_q;
  logic [W-1:0] count_d;

  // Next count: step only when enabled and not yet saturated.
  always_comb begin
    count_d = count_q;
    if (en_i && (count_q != {W{1'b1}})) begin
      count_d = count_q + W'(1);
    end else begin
      count_d = count_q;
    end
  end

  // Count register with asynchronous clear.
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      count_q <= {W{1'b0}};
    end else begin
      count_q <= count_d;
    end
  end

  assign count_o = count_q;

endmodule

// File: rtl/pipeline_ctrl.sv
// Pipeline hazard controller: load-use stall, branch/jump flush and a multi-cycle
// multiply freeze, with zero-latency control outputs and a saturating stall counter.
module pipeline_ctrl
  import pipeline_ctrl_pkg::*;
#(
  parameter int MUL_CYCLES = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   IDEX_MemRead,
  input  logic [REG_W-1:0]       IDEX_Rt,
  input  logic [REG_W-1:0]       IFID_Rs,
  input  logic [REG_W-1:0]       IFID_Rt,
  input  logic                   branch_taken,
  input  logic                   jump,
  input  logic                   mul_start,
  output logic                   PC_write,
  output logic                   IFID_write,
  output logic                   IF_flush,
  output logic                   IDEX_write,
  output logic                   IDEX_bubble,
  output logic                   EXMEM_bubble,
  output logic                   busy,
  output logic [STALL_CNT_W-1:0] stall_count
);

  // Wait counts down to zero inclusive, so the freeze lasts MUL_CYCLES-1 cycles.
  localparam logic [MUL_CNT_W-1:0] MUL_RELOAD = MUL_CNT_W'(MUL_CYCLES - 2);

  state_e               state_q;
  state_e               state_d;
  logic [MUL_CNT_W-1:0] mul_cnt_q;
  logic [MUL_CNT_W-1:0] mul_cnt_d;
  logic                 load_use_s;
  ctrl_t                ctrl_s;

  assign load_use_s = load_use_hazard(IDEX_MemRead, IDEX_Rt, IFID_Rs, IFID_Rt);

  // Next-state logic for the RUN / MUL_WAIT machine and the wait counter.
  always_comb begin
    state_d   = state_q;
    mul_cnt_d = mul_cnt_q;
    case (state_q)
      RUN: begin
        if (mul_start) begin
          state_d   = MUL_WAIT;
          mul_cnt_d = MUL_RELOAD;
        end else begin
          state_d   = RUN;
          mul_cnt_d = mul_cnt_q;
        end
      end
      MUL_WAIT: begin
        if (mul_cnt_q == {MUL_CNT_W{1'b0}}) begin
          state_d   = RUN;
          mul_cnt_d = {MUL_CNT_W{1'b0}};
        end else begin
          state_d   = MUL_WAIT;
          mul_cnt_d = mul_cnt_q - MUL_CNT_W'(1);
        end
      end
      default: begin
        state_d   = RUN;
        mul_cnt_d = {MUL_CNT_W{1'b0}};
      end
    endcase
  end

  // State and wait-counter registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= RUN;
      mul_cnt_q <= {MUL_CNT_W{1'b0}};
    end else begin
      state_q   <= state_d;
      mul_cnt_q <= mul_cnt_d;
    end
  end

  // Control word; a stall outranks a flush so the held ID instruction is not lost.
  always_comb begin
    ctrl_s = CTRL_RUN;
    if (!reset) begin
      ctrl_s = CTRL_RESET;
    end else if (state_q == MUL_WAIT) begin
      ctrl_s = CTRL_MULW;
    end else if (load_use_s) begin
      ctrl_s = CTRL_STALL;
    end else if (branch_taken || jump) begin
      ctrl_s = CTRL_FLUSH;
    end else begin
      ctrl_s = CTRL_RUN;
    end
  end

  assign PC_write     = ctrl_s.pc_write;
  assign IFID_write   = ctrl_s.ifid_write;
  assign IF_flush     = ctrl_s.if_flush;
  assign IDEX_write   = ctrl_s.idex_write;
  assign IDEX_bubble  = ctrl_s.idex_bubble;
  assign EXMEM_bubble = ctrl_s.exmem_bubble;
  assign busy         = ctrl_s.busy;

  sat_counter #(
    .W(STALL_CNT_W)
  ) u_stall_cnt (
    .clk    (clk),
    .clr_n  (reset),
    .en_i   (~ctrl_s.pc_write),
    .count_o(stall_count)
  );

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Directed self-checking bench for pipeline_ctrl with hand-computed expectations.
module tb_pipeline_ctrl;

  logic        clk;
  logic        reset;
  logic        IDEX_MemRead;
  logic [4:0]  IDEX_Rt;
  logic [4:0]  IFID_Rs;
  logic [4:0]  IFID_Rt;
  logic        branch_taken;
  logic        jump;
  logic        mul_start;
  logic        PC_write;
  logic        IFID_write;
  logic        IF_flush;
  logic        IDEX_write;
  logic        IDEX_bubble;
  logic        EXMEM_bubble;
  logic        busy;
  logic [15:0] stall_count;

  int n_checks = 0;
  int n_fail   = 0;

  // {PC_write, IFID_write, IF_flush, IDEX_write, IDEX_bubble, EXMEM_bubble, busy}
  localparam logic [6:0] E_RUN   = 7'b1101000;
  localparam logic [6:0] E_STALL = 7'b0001100;
  localparam logic [6:0] E_FLUSH = 7'b1111000;
  localparam logic [6:0] E_MULW  = 7'b0000011;
  localparam logic [6:0] E_RST   = 7'b0000110;

  pipeline_ctrl #(.MUL_CYCLES(4)) dut (
    .clk         (clk),
    .reset       (reset),
    .IDEX_MemRead(IDEX_MemRead),
    .IDEX_Rt     (IDEX_Rt),
    .IFID_Rs     (IFID_Rs),
    .IFID_Rt     (IFID_Rt),
    .branch_taken(branch_taken),
    .jump        (jump),
    .mul_start   (mul_start),
    .PC_write    (PC_write),
    .IFID_write  (IFID_write),
    .IF_flush    (IF_flush),
    .IDEX_write  (IDEX_write),
    .IDEX_bubble (IDEX_bubble),
    .EXMEM_bubble(EXMEM_bubble),
    .busy        (busy),
    .stall_count (stall_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [6:0] ctrl_vec();
    return {PC_write, IFID_write, IF_flush, IDEX_write, IDEX_bubble, EXMEM_bubble, busy};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic mr, input logic [4:0] ert, input logic [4:0] rs,
                       input logic [4:0] rt, input logic br, input logic jp, input logic ms);
    IDEX_MemRead = mr;
    IDEX_Rt      = ert;
    IFID_Rs      = rs;
    IFID_Rt      = rt;
    branch_taken = br;
    jump         = jp;
    mul_start    = ms;
    #1;
  endtask

  initial begin
    reset = 1'b0;
    drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
    #2;
    check("reset_ctrl", 32'(ctrl_vec()), 32'(E_RST));
    check("reset_cnt", 32'(stall_count), 32'd0);

    tick();
    reset = 1'b1;
    #1;
    check("run_idle", 32'(ctrl_vec()), 32'(E_RUN));

    // Load-use on Rs, one cycle
    tick();
    drive(1'b1, 5'd5, 5'd5, 5'd0, 1'b0, 1'b0, 1'b0);
    check("lu_rs_ctrl", 32'(ctrl_vec()), 32'(E_STALL));
    check("lu_rs_cnt0", 32'(stall_count), 32'd0);
    tick();
    drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
    check("lu_rs_cnt1", 32'(stall_count), 32'd1);
    check("lu_rs_after", 32'(ctrl_vec()), 32'(E_RUN));

    // Load-use on Rt; then a non-load match must not stall
    drive(1'b1, 5'd7, 5'd3, 5'd7, 1'b0, 1'b0, 1'b0);
    check("lu_rt_ctrl", 32'(ctrl_vec()), 32'(E_STALL));
    tick();
    drive(1'b0, 5'd7, 5'd7, 5'd7, 1'b0, 1'b0, 1'b0);
    check("no_load_match", 32'(ctrl_vec()), 32'(E_RUN));
    check("lu_rt_cnt", 32'(stall_count), 32'd2);

    // $zero destination never stalls; mismatching registers never stall
    drive(1'b1, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
    check("lu_zero", 32'(ctrl_vec()), 32'(E_RUN));
    drive(1'b1, 5'd9, 5'd8, 5'd10, 1'b0, 1'b0, 1'b0);
    check("lu_nomatch", 32'(ctrl_vec()), 32'(E_RUN));

    // Stall beats branch; then branch flushes; jump flushes
    tick();
    drive(1'b1, 5'd5, 5'd5, 5'd0, 1'b1, 1'b0, 1'b0);
    check("br_with_lu", 32'(ctrl_vec()), 32'(E_STALL));
    tick();
    drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b1, 1'b0, 1'b0);
    check("br_flush", 32'(ctrl_vec()), 32'(E_FLUSH));
    drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0);
    check("jmp_flush", 32'(ctrl_vec()), 32'(E_FLUSH));
    check("br_cnt", 32'(stall_count), 32'd3);

    // Multiply: issue cycle is plain RUN, then a 3-cycle freeze ignoring jump
    tick();
    drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1);
    check("mul_issue", 32'(ctrl_vec()), 32'(E_RUN));
    for (int i = 0; i < 3; i++) begin
      tick();
      drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0);
      check($sformatf("mul_wait%0d", i), 32'(ctrl_vec()), 32'(E_MULW));
    end
    tick();
    check("mul_done_jmp", 32'(ctrl_vec()), 32'(E_FLUSH));
    check("mul_cnt", 32'(stall_count), 32'd6);

    // Multiply coincident with load-use: stall, freeze, stall re-evaluated on return
    drive(1'b1, 5'd4, 5'd4, 5'd0, 1'b0, 1'b0, 1'b1);
    check("mul_lu_issue", 32'(ctrl_vec()), 32'(E_STALL));
    for (int i = 0; i < 3; i++) begin
      tick();
      drive(1'b1, 5'd4, 5'd4, 5'd0, 1'b1, 1'b0, 1'b1);
      check($sformatf("mul_lu_wait%0d", i), 32'(ctrl_vec()), 32'(E_MULW));
    end
    tick();
    drive(1'b1, 5'd4, 5'd4, 5'd0, 1'b0, 1'b0, 1'b0);
    check("mul_lu_return", 32'(ctrl_vec()), 32'(E_STALL));
    tick();
    drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
    check("mul_lu_run", 32'(ctrl_vec()), 32'(E_RUN));
    check("mul_lu_cnt", 32'(stall_count), 32'd11);

    // Reset in the second freeze cycle aborts the wait
    drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1);
    tick();
    drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
    check("abort_w1", 32'(busy), 32'd1);
    tick();
    check("abort_w2", 32'(busy), 32'd1);
    reset = 1'b0;
    #1;
    check("abort_ctrl", 32'(ctrl_vec()), 32'(E_RST));
    check("abort_cnt", 32'(stall_count), 32'd0);
    tick();
    tick();
    reset = 1'b1;
    #1;
    check("abort_run", 32'(ctrl_vec()), 32'(E_RUN));
    tick();
    check("abort_run2", 32'(ctrl_vec()), 32'(E_RUN));
    check("abort_cnt2", 32'(stall_count), 32'd0);

    // Saturation of the stall counter
    drive(1'b1, 5'd6, 5'd6, 5'd0, 1'b0, 1'b0, 1'b0);
    repeat (65534) @(posedge clk);
    #1;
    check("sat_fffe", 32'(stall_count), 32'h0000FFFE);
    repeat (6) @(posedge clk);
    #1;
    check("sat_ffff", 32'(stall_count), 32'h0000FFFF);
    drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
    tick();
    check("sat_hold", 32'(stall_count), 32'h0000FFFF);
    check("sat_run", 32'(ctrl_vec()), 32'(E_RUN));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
